map_sst_engine: RTL and testbench
=================================

# map_sst_engine

Save-state sequencer that sits directly upstream of a mapper's save-state register port. It walks the mapper's 128-entry save-state address space. On save it streams the mapper's register bytes out to the host buffer; on load it streams host bytes back into the mapper through the register-write strobe. Before any register is touched on load, it checks the stored mapper index against the running mapper.

## Interface
Parameters:
- SETTLE, 2, clk cycles between driving sst_addr and sampling sst_di (covers the mapper's combinational read mux).
- WR_HOLD, 4, clk cycles sst_we_reg is held high per write. Must span at least one full M2 period so a negedge-M2 register captures it.
- IDX_ADDR, 127, save-state address holding the mapper index.

Ports:
- clk  in  1  system clock. Single clock domain.
- rst  in  1  reset, asynchronous, active-high.
- start_save  in  1  one-cycle request to begin a save.
- start_load  in  1  one-cycle request to begin a load.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at completion of save or load, success or error.
- err  out  1  set on load index mismatch; cleared by the next accepted start.
- sst_act  out  1  save-state mode to mapper.
- sst_addr  out  8  save-state register address.
- sst_we_reg  out  1  register write strobe.
- sst_dato  out  8  write data to mapper.
- sst_di  in  8  read data from mapper (combinational function of sst_addr).
- tx_data  out  8  save byte to host.
- tx_valid  out  1  save byte valid.
- tx_ready  in  1  host accepts byte.
- rx_data  in  8  load byte from host.
- rx_valid  in  1  load byte valid.
- rx_ready  out  1  engine accepts byte.

## Operation
- Stream order, save and load: byte 0 is the mapper index (address IDX_ADDR), then addresses 0..126 ascending. Total 128 bytes.
- States:
  - IDLE
  - S_SETTLE, S_SEND (save)
  - L_HDR_SETTLE, L_HDR, L_RECV, L_WRITE (load)
  - FIN
- IDLE:
  - start_save moves to S_SETTLE with sst_addr=IDX_ADDR.
  - start_load moves to L_HDR_SETTLE with sst_addr=IDX_ADDR.
  - If both are asserted in the same cycle, save wins.
  - Starts are ignored while busy.
  - An accepted start clears err and raises busy and sst_act.
- S_SETTLE: count SETTLE cycles, then register sst_di into tx_data and go to S_SEND.
- S_SEND:
  - tx_valid high; tx_data stable until tx_ready.
  - On handshake (tx_valid & tx_ready): if 128 bytes are sent, go to FIN.
  - Otherwise advance the address (IDX_ADDR→0, then +1) and return to S_SETTLE.
- L_HDR_SETTLE: wait SETTLE cycles, then go to L_HDR.
- L_HDR:
  - rx_ready high.
  - On rx handshake, compare rx_data with sst_di.
  - Mismatch sets err and goes to FIN. No write has been issued.
  - Match sets sst_addr=0 and goes to L_RECV.
- L_RECV: rx_ready high. On handshake, latch rx_data into sst_dato and go to L_WRITE.
- L_WRITE:
  - sst_we_reg high for WR_HOLD cycles; sst_addr and sst_dato stay stable throughout.
  - Then, if sst_addr==126, go to FIN; else sst_addr+1 and go to L_RECV.
- FIN:
  - done pulses one cycle.
  - busy and sst_act drop in the same cycle.
  - Return to IDLE.
- sst_addr is an 8-bit register; the walk never exceeds 127. sst_addr is 0 in IDLE.
- The address counter and byte counter never wrap. The 128th byte terminates the walk.

## Timing
- Reset values: busy=0, done=0, err=0, sst_act=0, sst_addr=0, sst_we_reg=0, sst_dato=0, tx_data=0, tx_valid=0, rx_ready=0. Takes effect immediately (asynchronous).
- Reset mid-operation drops sst_act and sst_we_reg at once. A partially loaded mapper is left as-is. No done pulse.
- Start to first tx_valid: 1 + SETTLE cycles.
- Save with tx_ready tied high: 128 × (SETTLE+1) + 2 cycles, start to done.
- Load with rx_valid tied high: (SETTLE+1) + 127 × (WR_HOLD+1) + 2 cycles.
- rx_ready is never high during L_WRITE or the settle states. Backpressure on either stream stalls the FSM indefinitely with all sst_* outputs stable.
- sst_we_reg is never asserted outside L_WRITE. It is never asserted while sst_addr or sst_dato changes.
- err holds until the next accepted start or reset.

## Test plan
- Save, model mapper with sst_di = addr XOR 0x5A and IDX=137 (0x89), tx_ready=1 -> 128 bytes 0x89, 0x5A, 0x5B, ..., 0x24. One done pulse. err=0.
- Save with tx_ready toggling randomly -> identical byte sequence. tx_data is never changed while tx_valid & !tx_ready.
- Load with header 0x89 matching the model and bytes 0..126 = 0xFF-addr -> 127 writes, each WR_HOLD cycles, to addresses 0..126 with the correct data. done pulse. err=0.
- Load with header 0x8A against mapper index 0x89 -> err=1, zero sst_we_reg pulses, done after the header byte only.
- start_save and start_load in the same cycle -> save runs. A start issued mid-save is ignored (byte count stays 128).
- rst asserted during L_WRITE of address 40 -> sst_we_reg and sst_act low in the same cycle, all outputs at reset values, no done. A subsequent save succeeds.

Source files
------------

// File: rtl/map_sst_engine.sv
// Save-state sequencer: walks the mapper's 128-entry save-state space, streaming
// register bytes to the host on save and writing host bytes back on load.
module map_sst_engine #(
  parameter int unsigned SETTLE   = 2,
  parameter int unsigned WR_HOLD  = 4,
  parameter logic [7:0]  IDX_ADDR = 8'd127
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_save,
  input  logic       start_load,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       sst_act,
  output logic [7:0] sst_addr,
  output logic       sst_we_reg,
  output logic [7:0] sst_dato,
  input  logic [7:0] sst_di,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready
);

  // state        | meaning
  // IDLE         | waiting for a start, sst_addr parked at 0
  // S_SETTLE     | save: let the mapper read mux settle on sst_addr
  // S_SEND       | save: offer tx_data to the host
  // L_HDR_SETTLE | load: let the index read settle
  // L_HDR        | load: take header byte, compare with running index
  // L_RECV       | load: take next register byte from the host
  // L_WRITE      | load: hold sst_we_reg for WR_HOLD cycles
  // FIN          | last cycle with busy high; done follows
  typedef enum logic [2:0] {
    IDLE, S_SETTLE, S_SEND, L_HDR_SETTLE, L_HDR, L_RECV, L_WRITE, FIN
  } state_t;

  localparam logic [7:0] SETTLE_TC = 8'(SETTLE - 1);
  localparam logic [7:0] WR_TC     = 8'(WR_HOLD - 1);
  localparam logic [7:0] LAST_ADDR = 8'd126;
  localparam logic [6:0] LAST_BYTE = 7'd127;

  state_t     state, state_nxt;
  logic [7:0] timer, timer_nxt;
  logic [6:0] byte_cnt, byte_cnt_nxt;
  logic [7:0] addr_nxt, dato_nxt, tx_data_nxt;
  logic       err_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      timer    <= '0;
      byte_cnt <= '0;
      sst_addr <= '0;
      sst_dato <= '0;
      tx_data  <= '0;
      err      <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      timer    <= timer_nxt;
      byte_cnt <= byte_cnt_nxt;
      sst_addr <= addr_nxt;
      sst_dato <= dato_nxt;
      tx_data  <= tx_data_nxt;
      err      <= err_nxt;
      done     <= (state == FIN);
    end
  end

  always_comb begin
    state_nxt    = state;
    timer_nxt    = timer;
    byte_cnt_nxt = byte_cnt;
    addr_nxt     = sst_addr;
    dato_nxt     = sst_dato;
    tx_data_nxt  = tx_data;
    err_nxt      = err;
    case (state)
      IDLE: begin
        if (start_save || start_load) begin
          addr_nxt     = IDX_ADDR;
          timer_nxt    = SETTLE_TC;
          byte_cnt_nxt = '0;
          err_nxt      = 1'b0;
          state_nxt    = start_save ? S_SETTLE : L_HDR_SETTLE;
        end
      end
      S_SETTLE: begin
        if (timer == '0) begin
          tx_data_nxt = sst_di;
          state_nxt   = S_SEND;
        end else begin
          timer_nxt = timer - 8'd1;
        end
      end
      S_SEND: begin
        if (tx_ready) begin
          if (byte_cnt == LAST_BYTE) begin
            state_nxt = FIN;
          end else begin
            // the index byte goes first, then the walk restarts at address 0
            addr_nxt     = (byte_cnt == '0) ? 8'd0 : sst_addr + 8'd1;
            byte_cnt_nxt = byte_cnt + 7'd1;
            timer_nxt    = SETTLE_TC;
            state_nxt    = S_SETTLE;
          end
        end
      end
      L_HDR_SETTLE: begin
        if (timer == '0) state_nxt = L_HDR;
        else             timer_nxt = timer - 8'd1;
      end
      L_HDR: begin
        if (rx_valid) begin
          if (rx_data != sst_di) begin
            err_nxt   = 1'b1;
            state_nxt = FIN;
          end else begin
            addr_nxt  = 8'd0;
            state_nxt = L_RECV;
          end
        end
      end
      L_RECV: begin
        if (rx_valid) begin
          dato_nxt  = rx_data;
          timer_nxt = WR_TC;
          state_nxt = L_WRITE;
        end
      end
      L_WRITE: begin
        if (timer == '0) begin
          if (sst_addr == LAST_ADDR) begin
            state_nxt = FIN;
          end else begin
            addr_nxt  = sst_addr + 8'd1;
            state_nxt = L_RECV;
          end
        end else begin
          timer_nxt = timer - 8'd1;
        end
      end
      FIN: begin
        addr_nxt  = 8'd0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // strobes decode straight from the state register so reset kills them at once
  assign busy       = (state != IDLE);
  assign sst_act    = (state != IDLE);
  assign tx_valid   = (state == S_SEND);
  assign rx_ready   = (state == L_HDR) || (state == L_RECV);
  assign sst_we_reg = (state == L_WRITE);

endmodule

// File: tb/tb_map_sst_engine.sv
// Randomised scoreboard bench for map_sst_engine: expected tx bytes and mapper
// writes come from a stream-level model; monitors pop and compare on handshakes.
`timescale 1ns/1ps
module tb_map_sst_engine;
  localparam int SETTLE   = 2;
  localparam int WR_HOLD  = 4;
  localparam logic [7:0] IDX_ADDR = 8'd127;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_save, start_load;
  logic       busy, done, err, sst_act, sst_we_reg;
  logic [7:0] sst_addr, sst_dato, sst_di;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready;

  always #5 clk = ~clk;

  map_sst_engine #(.SETTLE(SETTLE), .WR_HOLD(WR_HOLD), .IDX_ADDR(IDX_ADDR)) dut (
    .clk(clk), .rst(rst), .start_save(start_save), .start_load(start_load),
    .busy(busy), .done(done), .err(err), .sst_act(sst_act),
    .sst_addr(sst_addr), .sst_we_reg(sst_we_reg), .sst_dato(sst_dato), .sst_di(sst_di),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
  );

  // mapper model: index at IDX_ADDR, every other register reads addr ^ 0x5A
  logic [7:0] map_idx = 8'h89;
  assign sst_di = (sst_addr == IDX_ADDR) ? map_idx : (sst_addr ^ 8'h5A);

  typedef struct packed { logic [7:0] addr; logic [7:0] data; } wr_t;
  logic [7:0] exp_tx[$];
  wr_t        exp_wr[$];
  logic [7:0] host_q[$];

  int n_cmp = 0, n_bad = 0;
  int cyc_cnt = 0, done_cnt = 0, done_cyc = 0, tx_cnt = 0, wr_cnt = 0;
  int first_txv_cyc = -1;
  int start_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // tx monitor
  logic       stall_prev = 1'b0, txv_prev = 1'b0;
  logic [7:0] tx_prev = 8'h00;
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
      txv_prev   = 1'b0;
    end else begin
      if (tx_valid && !txv_prev && exp_tx.size() == 128) first_txv_cyc = cyc_cnt;
      if (stall_prev && tx_valid) chk("tx_hold", tx_data, tx_prev);
      if (tx_valid && tx_ready) begin
        tx_cnt++;
        chk("tx_expected_pending", exp_tx.size() != 0, 1);
        if (exp_tx.size() != 0) chk("tx_byte", tx_data, exp_tx.pop_front());
      end
      stall_prev = tx_valid && !tx_ready;
      tx_prev    = tx_data;
      txv_prev   = tx_valid;
    end
  end

  // mapper write monitor
  int         we_len = 0;
  logic [7:0] we_addr = 8'h00, we_dat = 8'h00;
  always @(negedge clk) begin
    if (rst) begin
      we_len = 0;
    end else if (sst_we_reg) begin
      chk("rx_ready_in_write", rx_ready, 0);
      if (we_len == 0) begin
        wr_t e;
        wr_cnt++;
        we_addr = sst_addr;
        we_dat  = sst_dato;
        chk("wr_expected_pending", exp_wr.size() != 0, 1);
        if (exp_wr.size() != 0) begin
          e = exp_wr.pop_front();
          chk("wr_addr", sst_addr, e.addr);
          chk("wr_data", sst_dato, e.data);
        end
      end else begin
        chk("wr_addr_stable", sst_addr, we_addr);
        chk("wr_data_stable", sst_dato, we_dat);
      end
      we_len++;
    end else if (we_len != 0) begin
      chk("wr_hold_len", we_len, WR_HOLD);
      we_len = 0;
    end
  end

  always @(negedge clk) begin
    if (!rst && done) begin
      done_cnt++;
      done_cyc = cyc_cnt;
      chk("busy_at_done", busy, 0);
      chk("act_at_done", sst_act, 0);
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_act"}, sst_act, 0);
    chk({tag, "_addr"}, sst_addr, 0);
    chk({tag, "_we"}, sst_we_reg, 0);
    chk({tag, "_dato"}, sst_dato, 0);
    chk({tag, "_txdata"}, tx_data, 0);
    chk({tag, "_txvalid"}, tx_valid, 0);
    chk({tag, "_rxready"}, rx_ready, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic s, input logic l);
    @(posedge clk); #1;
    start_save = s;
    start_load = l;
    start_cyc  = cyc_cnt;
    @(posedge clk); #1;
    start_save = 1'b0;
    start_load = 1'b0;
  endtask

  task automatic expect_save();
    exp_tx.push_back(map_idx);
    for (int a = 0; a < 127; a++) exp_tx.push_back(8'(a) ^ 8'h5A);
  endtask

  task automatic expect_load(input logic [7:0] hdr, input bit rnd_data);
    logic [7:0] d;
    host_q.delete();
    host_q.push_back(hdr);
    for (int a = 0; a < 127; a++) begin
      d = rnd_data ? 8'($urandom) : 8'hFF - 8'(a);
      host_q.push_back(d);
      if (hdr == map_idx) exp_wr.push_back('{addr: 8'(a), data: d});
    end
  endtask

  task automatic run_save(input bit rnd, input bit mid_start);
    int target, n;
    int tx0;
    bit mid_done;
    target = done_cnt + 1; n = 0; mid_done = 0; tx0 = tx_cnt;
    while (done_cnt < target && n < 5000) begin
      tx_ready   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start_load = mid_start && !mid_done && (tx_cnt - tx0 >= 50);
      if (start_load) begin
        mid_done = 1;
        chk("busy_mid_save", busy, 1);
      end
      @(posedge clk); #1;
      n++;
    end
    tx_ready   = 1'b0;
    start_load = 1'b0;
    chk("save_done_in_budget", done_cnt >= target, 1);
  endtask

  task automatic run_load(input bit rnd, input int abort_addr, output int consumed, output bit aborted);
    int target, n;
    bit hs;
    target = done_cnt + 1; n = 0; consumed = 0; aborted = 0;
    while (done_cnt < target && n < 8000) begin
      rx_valid = (host_q.size() > 0) && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
      rx_data  = (host_q.size() > 0) ? host_q[0] : 8'h00;
      @(negedge clk);
      hs = rx_valid && rx_ready;
      if (abort_addr >= 0 && sst_we_reg && sst_addr == 8'(abort_addr)) begin
        aborted = 1;
        break;
      end
      @(posedge clk); #1;
      if (hs) begin
        void'(host_q.pop_front());
        consumed++;
      end
      n++;
    end
    rx_valid = 1'b0;
    if (abort_addr < 0) chk("load_done_in_budget", done_cnt >= target, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, tx0, wr0, used;
    bit ab;
    rst = 1'b1; start_save = 1'b0; start_load = 1'b0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    idle(2);
    check_reset_vals("por");
    @(negedge clk); rst = 1'b0;
    idle(2);

    // save, host always ready: exact byte stream and latencies
    expect_save();
    d0 = done_cnt; tx0 = tx_cnt; wr0 = wr_cnt;
    do_start(1'b1, 1'b0);
    chk("save1_busy", busy, 1);
    chk("save1_act", sst_act, 1);
    run_save(0, 0);
    idle(5);
    chk("save1_bytes", tx_cnt - tx0, 128);
    chk("save1_left", exp_tx.size(), 0);
    chk("save1_writes", wr_cnt - wr0, 0);
    chk("save1_done_pulses", done_cnt - d0, 1);
    chk("save1_err", err, 0);
    chk("save1_first_tx_lat", first_txv_cyc - start_cyc, 1 + SETTLE);
    chk("save1_done_lat", done_cyc - start_cyc, 128 * (SETTLE + 1) + 2);
    chk("save1_addr_idle", sst_addr, 0);

    // save with random backpressure, then again with a random mapper index
    for (int t = 0; t < 2; t++) begin
      if (t == 1) map_idx = 8'($urandom);
      expect_save();
      d0 = done_cnt; tx0 = tx_cnt;
      do_start(1'b1, 1'b0);
      run_save(1, 0);
      idle(3);
      chk("save_rnd_bytes", tx_cnt - tx0, 128);
      chk("save_rnd_left", exp_tx.size(), 0);
      chk("save_rnd_done_pulses", done_cnt - d0, 1);
    end
    map_idx = 8'h89;

    // load with matching header, host always valid
    expect_load(8'h89, 0);
    d0 = done_cnt; wr0 = wr_cnt;
    do_start(1'b0, 1'b1);
    chk("load1_busy", busy, 1);
    run_load(0, -1, used, ab);
    idle(5);
    chk("load1_writes", wr_cnt - wr0, 127);
    chk("load1_left", exp_wr.size(), 0);
    chk("load1_consumed", used, 128);
    chk("load1_err", err, 0);
    chk("load1_done_pulses", done_cnt - d0, 1);
    chk("load1_done_lat", done_cyc - start_cyc, (SETTLE + 1) + 127 * (WR_HOLD + 1) + 2);

    // load with random data, random index and random host stalls
    map_idx = 8'($urandom);
    expect_load(map_idx, 1);
    d0 = done_cnt; wr0 = wr_cnt;
    do_start(1'b0, 1'b1);
    run_load(1, -1, used, ab);
    idle(3);
    chk("load_rnd_writes", wr_cnt - wr0, 127);
    chk("load_rnd_left", exp_wr.size(), 0);
    chk("load_rnd_done_pulses", done_cnt - d0, 1);
    map_idx = 8'h89;

    // load with wrong header: error, no writes, only header consumed
    expect_load(8'h8A, 0);
    d0 = done_cnt; wr0 = wr_cnt;
    do_start(1'b0, 1'b1);
    run_load(0, -1, used, ab);
    idle(5);
    chk("load_bad_err", err, 1);
    chk("load_bad_writes", wr_cnt - wr0, 0);
    chk("load_bad_consumed", used, 1);
    chk("load_bad_done_pulses", done_cnt - d0, 1);
    chk("load_bad_done_lat", done_cyc - start_cyc, SETTLE + 3);
    host_q.delete();
    idle(5);
    chk("err_holds", err, 1);

    // simultaneous starts: save wins; a start during the save is ignored
    expect_save();
    d0 = done_cnt; tx0 = tx_cnt; wr0 = wr_cnt;
    do_start(1'b1, 1'b1);
    chk("both_err_cleared", err, 0);
    chk("both_tx_path", rx_ready, 0);
    run_save(1, 1);
    idle(5);
    chk("both_bytes", tx_cnt - tx0, 128);
    chk("both_left", exp_tx.size(), 0);
    chk("both_writes", wr_cnt - wr0, 0);
    chk("both_done_pulses", done_cnt - d0, 1);
    chk("both_busy_after", busy, 0);

    // reset while writing address 40
    expect_load(8'h89, 1);
    do_start(1'b0, 1'b1);
    run_load(1, 40, used, ab);
    chk("abort_reached_addr40", ab, 1);
    d0 = done_cnt;
    #2 rst = 1'b1;
    #1;
    check_reset_vals("midrst");
    @(posedge clk); @(negedge clk); #2 rst = 1'b0;
    exp_wr.delete();
    host_q.delete();
    idle(10);
    chk("midrst_no_done", done_cnt - d0, 0);
    chk("midrst_busy", busy, 0);

    // save after the aborted load
    expect_save();
    d0 = done_cnt; tx0 = tx_cnt;
    do_start(1'b1, 1'b0);
    run_save(1, 0);
    idle(3);
    chk("post_rst_bytes", tx_cnt - tx0, 128);
    chk("post_rst_left", exp_tx.size(), 0);
    chk("post_rst_done_pulses", done_cnt - d0, 1);
    chk("post_rst_err", err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
